// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared constants and encodings for the integer ALU datapath.
//   ALU_WIDTH : datapath width in bits
//   CLA_W     : width of one first-level carry-lookahead cell
//   op_e      : isSub encoding   (ADD / SUB)
//   mode_e    : isSign encoding  (UNSIGNED / SIGNED overflow rule)
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_WIDTH = 32;
    localparam int CLA_W     = 4;

    typedef enum logic {
        ADD = 1'b0,
        SUB = 1'b1
    } op_e;

    typedef enum logic {
        UNSIGNED = 1'b0,
        SIGNED   = 1'b1
    } mode_e;

endpackage : alu_pkg

// File: rtl/cla4.sv
// ---------------------------------------------------------------------------
// cla4
//   4-bit carry-lookahead cell. All internal carries are flat
//   sum-of-products of the bit generate/propagate terms, so there is no
//   ripple inside the cell. Group G/P feed the second-level lookahead.
//   a, b : operand nibbles
//   cin  : carry into bit 0
//   s    : sum nibble
//   G    : group generate (carry out independent of cin)
//   P    : group propagate (cin passes through all four bits)
//   c3   : carry into bit 3, used for signed overflow on the top group
// ---------------------------------------------------------------------------
module cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       G,
    output logic       P,
    output logic       c3
);

    logic [3:0] g;
    logic [3:0] p;
    logic       c1;
    logic       c2;

    assign g = a & b;
    assign p = a ^ b;

    assign c1 = g[0] | (p[0] & cin);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);

    assign s = p ^ {c3, c2, c1, cin};

    assign G = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);
    assign P = &p;

endmodule : cla4

// File: rtl/add32_sync.sv
// ---------------------------------------------------------------------------
// add32_sync
//   Registered two's-complement adder/subtractor with a per-operation
//   overflow flag (signed or unsigned rule). One-cycle latency, a new
//   operation may be issued every cycle, no handshake.
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset (clears result and Overflow)
//   A, B     : operands
//   isSub    : 0 = A+B, 1 = A-B
//   isSign   : 1 = signed overflow rule, 0 = unsigned carry/borrow rule
//   result   : registered sum/difference, modulo 2^WIDTH
//   Overflow : registered overflow flag for the operation in result
// ---------------------------------------------------------------------------
module add32_sync
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             isSub,
    input  logic             isSign,
    output logic [WIDTH-1:0] result,
    output logic             Overflow
);

    localparam int NG = WIDTH / CLA_W;

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic [NG-1:0]    grp_g;
    logic [NG-1:0]    grp_p;
    logic [NG-1:0]    c3_w;
    logic [NG:0]      gc;        // carry into each group; gc[NG] = cout
    logic             cout;
    logic             c_msb;     // carry into the sign bit
    logic             ovf_d;
    logic [WIDTH-1:0] result_q;
    logic             ovf_q;

    // Subtraction is A + ~B + 1; the +1 enters as the carry into group 0.
    assign b_eff = (op_e'(isSub) == SUB) ? ~B : B;

    // First level: one lookahead cell per nibble.
    genvar gi;
    generate
        for (gi = 0; gi < NG; gi++) begin : g_cla
            cla4 u_cla4 (
                .a   (A[gi*CLA_W +: CLA_W]),
                .b   (b_eff[gi*CLA_W +: CLA_W]),
                .cin (gc[gi]),
                .s   (sum[gi*CLA_W +: CLA_W]),
                .G   (grp_g[gi]),
                .P   (grp_p[gi]),
                .c3  (c3_w[gi])
            );
        end
    endgenerate

    // Second level: each group carry is the flat OR of
    //   G[j] & P[j+1] & ... & P[i-1]   for all j < i, plus
    //   cin  & P[0]   & ... & P[i-1].
    // The loops only enumerate product terms; no carry feeds another.
    always_comb begin : p_glook
        logic term;
        logic acc;
        gc    = '0;
        gc[0] = isSub;
        for (int i = 1; i <= NG; i++) begin
            acc  = 1'b0;
            for (int j = 0; j < i; j++) begin
                term = grp_g[j];
                for (int k = j + 1; k < i; k++) begin
                    term = term & grp_p[k];
                end
                acc = acc | term;
            end
            term = isSub;
            for (int k = 0; k < i; k++) begin
                term = term & grp_p[k];
            end
            gc[i] = acc | term;
        end
    end

    assign cout  = gc[NG];
    assign c_msb = c3_w[NG-1];

    // Only the top cell's c3 matters; the rest are intentionally dropped.
    logic unused_c3;
    assign unused_c3 = ^c3_w[NG-2:0];

    // Signed: carry into MSB differs from carry out.
    // Unsigned: carry for add, inverted carry (borrow) for sub.
    always_comb begin
        ovf_d = cout ^ isSub;
        if (mode_e'(isSign) == SIGNED) begin
            ovf_d = cout ^ c_msb;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            result_q <= sum;
            ovf_q    <= ovf_d;
        end
    end

    assign result   = result_q;
    assign Overflow = ovf_q;

endmodule : add32_sync

// File: tb/tb_add32_sync.sv
// ---------------------------------------------------------------------------
// tb_add32_sync
//   Directed vectors with hand-computed results, a back-to-back burst, and
//   a randomized run against an arithmetic golden model with a mid-stream
//   reset. Inputs change on the falling edge; outputs are sampled 1 time
//   unit after the rising edge that loads them.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_add32_sync;

    logic        clk;
    logic        rst;
    logic [31:0] A;
    logic [31:0] B;
    logic        isSub;
    logic        isSign;
    logic [31:0] result;
    logic        Overflow;

    int checks   = 0;
    int failures = 0;

    add32_sync u_dut (
        .clk      (clk),
        .rst      (rst),
        .A        (A),
        .B        (B),
        .isSub    (isSub),
        .isSign   (isSign),
        .result   (result),
        .Overflow (Overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {Overflow, result} against expectation
    task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got ovf=%b res=%h exp ovf=%b res=%h",
                     tag, got[32], got[31:0], exp[32], exp[31:0]);
        end
    endtask

    task automatic drive(input logic r, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic sgn);
        @(negedge clk);
        rst    = r;
        A      = a;
        B      = b;
        isSub  = sub;
        isSign = sgn;
    endtask

    // Issue one op, wait for its load edge, compare.
    task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic sub, input logic sgn,
                      input logic [31:0] exp_r, input logic exp_o);
        drive(1'b0, a, b, sub, sgn);
        @(posedge clk); #1;
        chk(tag, {Overflow, result}, {exp_o, exp_r});
    endtask

    function automatic logic [32:0] golden(input logic [31:0] a, input logic [31:0] b,
                                           input logic sub, input logic sgn);
        logic [32:0] wide;
        longint      s;
        logic        o;
        if (sub) begin
            wide = {1'b0, a} - {1'b0, b};
            s    = longint'($signed(a)) - longint'($signed(b));
            o    = (a < b);
        end else begin
            wide = {1'b0, a} + {1'b0, b};
            s    = longint'($signed(a)) + longint'($signed(b));
            o    = wide[32];
        end
        if (sgn) o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        return {o, wide[31:0]};
    endfunction

    initial begin
        rst = 1'b1; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF; isSub = 1'b0; isSign = 1'b0;

        // Reset held for two edges with all-ones operands presented.
        @(posedge clk); #1;
        chk("rst_edge0", {Overflow, result}, 33'h0);
        @(posedge clk); #1;
        chk("rst_edge1", {Overflow, result}, 33'h0);

        // First edge after reset loads the sum (unsigned carry out).
        op("post_rst", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'hFFFF_FFFE, 1'b1);

        // Signed
        op("s_neg_add",  32'hFFFF_FF9C, 32'hFFFF_FF9C, 1'b0, 1'b1, 32'hFFFF_FF38, 1'b0);
        op("s_max_p1",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 32'h8000_0000, 1'b1);
        op("s_min_m1",   32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1);
        op("s_min_pneg", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1);
        op("s_min_mmin", 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 32'h0000_0000, 1'b0);
        op("s_m1_p1",    32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_0000, 1'b0);

        // Unsigned
        op("u_wrap",     32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1);
        op("u_5m7",      32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b1);
        op("u_7m5",      32'h0000_0007, 32'h0000_0005, 1'b1, 1'b0, 32'h0000_0002, 1'b0);
        op("u_0m0",      32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b0);
        op("u_am0",      32'h1234_5678, 32'h0000_0000, 1'b1, 1'b0, 32'h1234_5678, 1'b0);
        op("u_min_mmin", 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b0);
        op("u_max_smax", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0);
        op("u_carry_ch", 32'h0FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h1000_0000, 1'b0);

        // Back-to-back, one op per cycle.
        op("b2b_0", 32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, 32'h0000_0007, 1'b0);
        op("b2b_1", 32'h0000_000A, 32'h0000_0014, 1'b1, 1'b1, 32'hFFFF_FFF6, 1'b0);
        op("b2b_2", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1);

        // Randomized run with a reset pulse in the middle.
        for (int n = 0; n < 1000; n++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            logic        rs;
            logic        rg;
            logic        rr;
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            rg = 1'($urandom_range(0, 1));
            rr = (n == 500);
            drive(rr, ra, rb, rs, rg);
            @(posedge clk); #1;
            if (rr) chk("rnd_rst", {Overflow, result}, 33'h0);
            else    chk("rnd", {Overflow, result}, golden(ra, rb, rs, rg));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety bound in case the clock or stimulus stalls.
    initial begin
        #200000;
        $display("FAIL timeout got=stalled exp=finish");
        $fatal(1, "timeout");
    end

endmodule : tb_add32_sync
